// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, data-register selector and default opcodes
// for the JTAG TAP slave.
package jtag_pkg;

  typedef enum logic [3:0] {
    Tlr     = 4'hF,
    Rti     = 4'hC,
    SelDr   = 4'h7,
    CapDr   = 4'h6,
    ShiftDr = 4'h2,
    Exit1Dr = 4'h1,
    PauseDr = 4'h3,
    Exit2Dr = 4'h0,
    UpdDr   = 4'h5,
    SelIr   = 4'h4,
    CapIr   = 4'hE,
    ShiftIr = 4'hA,
    Exit1Ir = 4'h9,
    PauseIr = 4'hB,
    Exit2Ir = 4'h8,
    UpdIr   = 4'hD
  } tap_state_e;

  typedef enum logic [1:0] {
    DrBypass = 2'd0,
    DrIdcode = 2'd1,
    DrUser   = 2'd2
  } dr_sel_e;

  localparam logic [3:0] DEF_INS_IDCODE = 4'b0001;
  localparam logic [3:0] DEF_INS_USER   = 4'b0010;

endpackage

// File: rtl/jtag_tap_slave_if.sv
// Pin-level bundle between a JTAG master (or bench) and the TAP slave,
// including the parallel USER register side-band toward core logic.
interface jtag_tap_slave_if
  import jtag_pkg::*;
#(
  parameter int unsigned DR_LEN = 8
);
  logic              tms;
  logic              tdi;
  logic              tdo;
  logic              tdo_en;
  logic [DR_LEN-1:0] user_in;
  logic [DR_LEN-1:0] user_out;
  logic              user_upd;
  tap_state_e        state;

  modport master (
    output tms, tdi, user_in,
    input  tdo, tdo_en, user_out, user_upd, state
  );

  modport slave (
    input  tms, tdi, user_in,
    output tdo, tdo_en, user_out, user_upd, state
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller state machine, advanced by TMS on
// the rising edge of TCK.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_d, state_q;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q <= Tlr;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Tlr:     state_d = tms_i ? Tlr     : Rti;
      Rti:     state_d = tms_i ? SelDr   : Rti;
      SelDr:   state_d = tms_i ? SelIr   : CapDr;
      CapDr:   state_d = tms_i ? Exit1Dr : ShiftDr;
      ShiftDr: state_d = tms_i ? Exit1Dr : ShiftDr;
      Exit1Dr: state_d = tms_i ? UpdDr   : PauseDr;
      PauseDr: state_d = tms_i ? Exit2Dr : PauseDr;
      Exit2Dr: state_d = tms_i ? UpdDr   : ShiftDr;
      UpdDr:   state_d = tms_i ? SelDr   : Rti;
      SelIr:   state_d = tms_i ? Tlr     : CapIr;
      CapIr:   state_d = tms_i ? Exit1Ir : ShiftIr;
      ShiftIr: state_d = tms_i ? Exit1Ir : ShiftIr;
      Exit1Ir: state_d = tms_i ? UpdIr   : PauseIr;
      PauseIr: state_d = tms_i ? Exit2Ir : PauseIr;
      Exit2Ir: state_d = tms_i ? UpdIr   : ShiftIr;
      UpdIr:   state_d = tms_i ? SelDr   : Rti;
      default: state_d = Tlr;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_slave.sv
// JTAG TAP slave: instruction register plus BYPASS, IDCODE and USER data
// registers, shifted MSB-first on rising TCK with TDO launched on falling TCK.
module jtag_tap_slave
  import jtag_pkg::*;
#(
  parameter int unsigned       IR_LEN     = 4,
  parameter int unsigned       DR_LEN     = 8,
  parameter logic [31:0]       IDCODE_VAL = 32'h1234_5001,
  parameter logic [IR_LEN-1:0] INS_IDCODE = IR_LEN'(DEF_INS_IDCODE),
  parameter logic [IR_LEN-1:0] INS_USER   = IR_LEN'(DEF_INS_USER)
) (
  input logic             tck,
  input logic             trst_n,
  jtag_tap_slave_if.slave bus
);

  tap_state_e        state;
  dr_sel_e           dr_sel;
  logic [IR_LEN-1:0] ir_q, ir_sr_q;
  logic              bypass_q;
  logic [31:0]       idcode_sr_q;
  logic [DR_LEN-1:0] user_sr_q, user_out_q;
  logic              user_upd_q;
  logic              tdo_q, tdo_en_q;
  logic              dr_msb;

  jtag_tap_fsm u_fsm (
    .tck     (tck),
    .trst_n  (trst_n),
    .tms_i   (bus.tms),
    .state_o (state)
  );

  // Anything other than the two known opcodes (including all-ones) is BYPASS.
  always_comb begin
    dr_sel = DrBypass;
    if (ir_q == INS_IDCODE) begin
      dr_sel = DrIdcode;
    end else if (ir_q == INS_USER) begin
      dr_sel = DrUser;
    end
  end

  always_comb begin
    dr_msb = bypass_q;
    unique case (dr_sel)
      DrIdcode: dr_msb = idcode_sr_q[31];
      DrUser:   dr_msb = user_sr_q[DR_LEN-1];
      default:  dr_msb = bypass_q;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_q        <= INS_IDCODE;
      ir_sr_q     <= '0;
      bypass_q    <= 1'b0;
      idcode_sr_q <= '0;
      user_sr_q   <= '0;
      user_out_q  <= '0;
      user_upd_q  <= 1'b0;
    end else begin
      user_upd_q <= 1'b0;
      case (state)
        Tlr:     ir_q    <= INS_IDCODE;
        CapIr:   ir_sr_q <= IR_LEN'(2'b01);
        ShiftIr: ir_sr_q <= {ir_sr_q[IR_LEN-2:0], bus.tdi};
        UpdIr:   ir_q    <= ir_sr_q;
        CapDr: begin
          unique case (dr_sel)
            DrIdcode: idcode_sr_q <= IDCODE_VAL;
            DrUser:   user_sr_q   <= bus.user_in;
            default:  bypass_q    <= 1'b0;
          endcase
        end
        ShiftDr: begin
          unique case (dr_sel)
            DrIdcode: idcode_sr_q <= {idcode_sr_q[30:0], bus.tdi};
            DrUser:   user_sr_q   <= {user_sr_q[DR_LEN-2:0], bus.tdi};
            default:  bypass_q    <= bus.tdi;
          endcase
        end
        UpdDr: begin
          if (dr_sel == DrUser) begin
            user_out_q <= user_sr_q;
            user_upd_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // TDO keeps its last value outside shift states; only the enable drops.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else if (state == ShiftIr) begin
      tdo_q    <= ir_sr_q[IR_LEN-1];
      tdo_en_q <= 1'b1;
    end else if (state == ShiftDr) begin
      tdo_q    <= dr_msb;
      tdo_en_q <= 1'b1;
    end else begin
      tdo_en_q <= 1'b0;
    end
  end

  assign bus.tdo      = tdo_q;
  assign bus.tdo_en   = tdo_en_q;
  assign bus.user_out = user_out_q;
  assign bus.user_upd = user_upd_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Directed bench for jtag_tap_slave: FSM walk table plus IR/DR scan sequences.
module tb_jtag_tap_slave;
  import jtag_pkg::*;

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic upd0, upd1, upd2;
  logic [31:0] dout;

  jtag_tap_slave_if #(.DR_LEN(8)) bus ();

  jtag_tap_slave #(
    .IR_LEN     (4),
    .DR_LEN     (8),
    .IDCODE_VAL (32'h1234_5001),
    .INS_IDCODE (4'b0001),
    .INS_USER   (4'b0010)
  ) dut (
    .tck    (tck),
    .trst_n (trst_n),
    .bus    (bus)
  );

  always #5 tck = ~tck;

  typedef struct packed {
    logic       tms;
    logic [3:0] st;
    logic       en;
  } fsm_vec_t;

  fsm_vec_t fsm_tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // Call in SHIFT_xR; collects the bit seen on TDO before each shifting edge.
  task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] out);
    out = '0;
    check("tdo_en in shift", bus.tdo_en, 1'b1);
    for (int i = 0; i < n; i++) begin
      out = {out[30:0], bus.tdo};
      step(i == n - 1, din[n-1-i]);
    end
  endtask

  task automatic enter_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic leave_dr();
    step(1'b1, 1'b0);
    upd0 = bus.user_upd;
    step(1'b0, 1'b0);
    upd1 = bus.user_upd;
    step(1'b0, 1'b0);
    upd2 = bus.user_upd;
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [31:0] cap);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(4, {28'h0, v}, cap);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    logic [31:0] hi;
    logic [31:0] lo;
    bus.tms = 1'b1;
    bus.tdi = 1'b0;
    bus.user_in = 8'h00;

    // state, tms, expected state, expected tdo_en
    fsm_tbl.push_back({1'b1, 4'hF, 1'b0}); fsm_tbl.push_back({1'b0, 4'hC, 1'b0});
    fsm_tbl.push_back({1'b0, 4'hC, 1'b0}); fsm_tbl.push_back({1'b1, 4'h7, 1'b0});
    fsm_tbl.push_back({1'b0, 4'h6, 1'b0}); fsm_tbl.push_back({1'b0, 4'h2, 1'b1});
    fsm_tbl.push_back({1'b0, 4'h2, 1'b1}); fsm_tbl.push_back({1'b1, 4'h1, 1'b0});
    fsm_tbl.push_back({1'b0, 4'h3, 1'b0}); fsm_tbl.push_back({1'b0, 4'h3, 1'b0});
    fsm_tbl.push_back({1'b1, 4'h0, 1'b0}); fsm_tbl.push_back({1'b0, 4'h2, 1'b1});
    fsm_tbl.push_back({1'b1, 4'h1, 1'b0}); fsm_tbl.push_back({1'b1, 4'h5, 1'b0});
    fsm_tbl.push_back({1'b0, 4'hC, 1'b0}); fsm_tbl.push_back({1'b1, 4'h7, 1'b0});
    fsm_tbl.push_back({1'b1, 4'h4, 1'b0}); fsm_tbl.push_back({1'b0, 4'hE, 1'b0});
    fsm_tbl.push_back({1'b0, 4'hA, 1'b1}); fsm_tbl.push_back({1'b1, 4'h9, 1'b0});
    fsm_tbl.push_back({1'b0, 4'hB, 1'b0}); fsm_tbl.push_back({1'b1, 4'h8, 1'b0});
    fsm_tbl.push_back({1'b0, 4'hA, 1'b1}); fsm_tbl.push_back({1'b1, 4'h9, 1'b0});
    fsm_tbl.push_back({1'b1, 4'hD, 1'b0}); fsm_tbl.push_back({1'b0, 4'hC, 1'b0});
    fsm_tbl.push_back({1'b1, 4'h7, 1'b0}); fsm_tbl.push_back({1'b1, 4'h4, 1'b0});
    fsm_tbl.push_back({1'b0, 4'hE, 1'b0}); fsm_tbl.push_back({1'b1, 4'h9, 1'b0});
    fsm_tbl.push_back({1'b0, 4'hB, 1'b0}); fsm_tbl.push_back({1'b1, 4'h8, 1'b0});
    fsm_tbl.push_back({1'b1, 4'hD, 1'b0}); fsm_tbl.push_back({1'b1, 4'h7, 1'b0});
    fsm_tbl.push_back({1'b0, 4'h6, 1'b0}); fsm_tbl.push_back({1'b1, 4'h1, 1'b0});
    fsm_tbl.push_back({1'b0, 4'h3, 1'b0}); fsm_tbl.push_back({1'b1, 4'h0, 1'b0});
    fsm_tbl.push_back({1'b1, 4'h5, 1'b0}); fsm_tbl.push_back({1'b1, 4'h7, 1'b0});
    fsm_tbl.push_back({1'b1, 4'h4, 1'b0}); fsm_tbl.push_back({1'b1, 4'hF, 1'b0});
    fsm_tbl.push_back({1'b0, 4'hC, 1'b0});

    // Reset values
    repeat (2) @(negedge tck);
    #1;
    check("reset state", bus.state, 4'hF);
    check("reset tdo", bus.tdo, 1'b0);
    check("reset tdo_en", bus.tdo_en, 1'b0);
    check("reset user_out", bus.user_out, 8'h00);
    check("reset user_upd", bus.user_upd, 1'b0);
    trst_n = 1'b1;

    // FSM walk through every state and arc
    foreach (fsm_tbl[i]) begin
      step(fsm_tbl[i].tms, 1'b0);
      check($sformatf("fsm state [%0d]", i), bus.state, fsm_tbl[i].st);
      check($sformatf("fsm tdo_en [%0d]", i), bus.tdo_en, fsm_tbl[i].en);
    end

    // IDCODE selected after TLR without any IR load
    enter_dr();
    shift_bits(32, 32'h0, dout);
    check("idcode stream", dout, 32'h1234_5001);
    check("idcode exit1", bus.state, 4'h1);
    leave_dr();
    check("idcode no upd", {upd0, upd1, upd2}, 3'b000);

    // USER scan
    load_ir(4'b0010, cap);
    check("ir capture user", cap, 32'h1);
    bus.user_in = 8'hA5;
    enter_dr();
    shift_bits(8, 32'h3C, dout);
    check("user tdo", dout, 32'hA5);
    leave_dr();
    check("user upd pulse", {upd0, upd1, upd2}, 3'b010);
    check("user out", bus.user_out, 8'h3C);

    // All-ones opcode is BYPASS: one-bit delay with leading capture 0
    load_ir(4'b1111, cap);
    check("ir capture ones", cap, 32'h1);
    enter_dr();
    shift_bits(9, 32'h1B3, dout);
    check("bypass tdo", dout, 32'h0D9);
    leave_dr();
    check("bypass no upd", {upd0, upd1, upd2}, 3'b000);
    check("bypass user_out", bus.user_out, 8'h3C);

    // USER scan split by a 10-cycle pause; USER_IN changed mid-pause
    load_ir(4'b0010, cap);
    bus.user_in = 8'h5A;
    enter_dr();
    shift_bits(4, 32'hC, hi);
    step(1'b0, 1'b0);
    bus.user_in = 8'hFF;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    check("pause state", bus.state, 4'h3);
    check("pause tdo_en", bus.tdo_en, 1'b0);
    step(1'b1, 1'b0);
    check("exit2 state", bus.state, 4'h0);
    step(1'b0, 1'b0);
    check("resume shift", bus.state, 4'h2);
    shift_bits(4, 32'h6, lo);
    check("paused tdo", {hi[3:0], lo[3:0]}, 8'h5A);
    leave_dr();
    check("paused upd", {upd0, upd1, upd2}, 3'b010);
    check("paused user_out", bus.user_out, 8'hC6);

    // Undefined opcode: zero-length DR pass, then a short bypass shift
    load_ir(4'b0111, cap);
    check("ir capture undef", cap, 32'h1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("undef exit1", bus.state, 4'h1);
    leave_dr();
    check("undef no upd", {upd0, upd1, upd2}, 3'b000);
    check("undef user_out", bus.user_out, 8'hC6);
    enter_dr();
    shift_bits(3, 32'h5, dout);
    check("undef bypass tdo", dout, 32'h2);
    leave_dr();

    // Async reset in the middle of a USER shift
    load_ir(4'b0010, cap);
    bus.user_in = 8'hFF;
    enter_dr();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("pre-reset tdo", bus.tdo, 1'b1);
    #2 trst_n = 1'b0;
    #1;
    check("trst state", bus.state, 4'hF);
    check("trst tdo_en", bus.tdo_en, 1'b0);
    check("trst tdo", bus.tdo, 1'b0);
    check("trst user_out", bus.user_out, 8'h00);
    check("trst user_upd", bus.user_upd, 1'b0);
    @(negedge tck);
    #1;
    trst_n = 1'b1;
    step(1'b0, 1'b0);
    enter_dr();
    shift_bits(32, 32'h0, dout);
    check("idcode after trst", dout, 32'h1234_5001);
    leave_dr();

    // Five TMS=1 from PAUSE_IR and from SHIFT_DR
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("at pause_ir", bus.state, 4'hB);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5 from pause_ir", bus.state, 4'hF);
    step(1'b0, 1'b0);
    enter_dr();
    check("at shift_dr", bus.state, 4'h2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5 from shift_dr", bus.state, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_slave.md
Name: jtag_tap_slave

Overview:
IEEE 1149.1-style TAP controller that consumes the TCK/TMS/TDI stream produced by the team's JTAG master and returns TDO. It implements the 16-state TAP FSM, an instruction register and three data registers: BYPASS, IDCODE and an 8-bit USER register with a parallel capture/update interface toward core logic. It is the device-side endpoint of the master in the same bench and in silicon.

Parameters:
IR_LEN, 4, instruction register width (>=2)
DR_LEN, 8, USER data register width
IDCODE_VAL, 32'h1234_5001, value captured by IDCODE (bit0 must be 1)
INS_IDCODE, 4'b0001, IDCODE opcode
INS_USER, 4'b0010, USER opcode

Ports:
TCK  in  1  sole clock; FSM and shift registers on posedge, TDO on negedge
TRST_N  in  1  asynchronous active-low reset
TMS  in  1  mode select, sampled posedge TCK
TDI  in  1  serial data in (master's TDO), sampled posedge TCK
TDO  out  1  serial data out (master's TDI), registered on negedge TCK
TDO_EN  out  1  high while in SHIFT_IR/SHIFT_DR (negedge-registered); external pad tristates TDO when low
USER_IN  in  DR_LEN  parallel value loaded at CAPTURE_DR when IR=USER
USER_OUT  out  DR_LEN  parallel value latched at UPDATE_DR when IR=USER
USER_UPD  out  1  one-TCK pulse, the cycle after entering UPDATE_DR with IR=USER
STATE  out  4  current TAP state (debug)

Behaviour:
- Reset (TRST_N=0, async): STATE=TLR, IR=INS_IDCODE, TDO=0, TDO_EN=0, USER_OUT=0, USER_UPD=0, all shift registers 0.
- Five consecutive TMS=1 posedges reach TLR from any state. In TLR, IR is forced to INS_IDCODE every cycle.
- FSM per standard: TLR -(0)-> RTI; RTI -(1)-> SEL_DR; SEL_DR -(1)-> SEL_IR, -(0)-> CAP_DR; SEL_IR -(1)-> TLR, -(0)-> CAP_IR.
- Each xR branch: CAP -(0)-> SHIFT, -(1)-> EXIT1; SHIFT -(1)-> EXIT1; EXIT1 -(0)-> PAUSE, -(1)-> UPDATE; PAUSE -(1)-> EXIT2; EXIT2 -(0)-> SHIFT, -(1)-> UPDATE; UPDATE -(0)-> RTI, -(1)-> SEL_DR. Unlisted TMS values hold the state.
- Shift order is MSB-first, matching the master. On each posedge in SHIFT_xR: sr <= {sr[W-2:0], TDI}. On negedge: TDO <= sr[W-1].
- The last bit is shifted on the posedge that leaves SHIFT with TMS=1, so N TMS=0 cycles followed by one TMS=1 cycle shift N+1 bits.
- CAP_IR: ir_sr <= {0..0,2'b01}. UPD_IR: IR <= ir_sr. Unknown opcodes and all-ones select BYPASS.
- CAP_DR loads the selected DR:
  - BYPASS: 1 bit, value 0.
  - IDCODE: 32 bits, IDCODE_VAL.
  - USER: DR_LEN bits, USER_IN.
- UPD_DR with IR=USER: USER_OUT <= user_sr; USER_UPD=1 for exactly one cycle. Other DRs have no update side effect.
- Registers hold during PAUSE/EXIT. Re-entering SHIFT from EXIT2 resumes without recapture.
- TRST_N asserted mid-shift: immediate return to reset values. USER_OUT is lost to 0 and no USER_UPD is generated.
- TDO when not shifting: holds its last value, TDO_EN=0.

Decomposition:
- Package jtag_pkg: 4-bit state encoding constants (TLR=4'hF, RTI=4'hC, SEL_DR=4'h7, CAP_DR=4'h6, SHIFT_DR=4'h2, EXIT1_DR=4'h1, PAUSE_DR=4'h3, EXIT2_DR=4'h0, UPD_DR=4'h5, SEL_IR=4'h4, CAP_IR=4'hE, SHIFT_IR=4'hA, EXIT1_IR=4'h9, PAUSE_IR=4'hB, EXIT2_IR=4'h8, UPD_IR=4'hD); default opcodes.
- Sub-module jtag_tap_fsm: TMS-driven state register plus next-state logic, outputting STATE. The top holds the IR, DRs and TDO mux.

Test Plan:
- TRST_N low mid-SHIFT_DR -> STATE=4'hF, TDO_EN=0, IR=4'b0001 immediately; TMS=1 x5 from any state -> TLR.
- Reset, RTI, enter SHIFT_DR with no IR load, shift 32 bits -> TDO stream MSB-first 0x12345001.
- Load IR=4'b0010 -> IR capture shifts out 4'b0001. Then DR scan with USER_IN=8'hA5, TDI=8'h3C -> TDO=8'hA5; USER_OUT=8'h3C, USER_UPD high exactly one cycle.
- IR=4'b1111, DR shift of 9 bits TDI=9'h1B3 -> TDO equals TDI delayed one bit with a leading 0; USER_OUT unchanged.
- USER scan paused: 4 bits, PAUSE_DR for 10 cycles, EXIT2 -> SHIFT, 4 more bits -> USER_OUT equals the full 8-bit pattern; no extra capture.
- IR=4'b0111 (undefined) -> behaves as BYPASS; CAP->EXIT1->UPD_DR with zero shift -> USER_OUT unchanged and no USER_UPD.
